// File: rtl/pattern_gen_if.sv
// Request/publish bundle between the game controller (master) and pattern_gen (slave).
// Handshake: start is a request level sampled only while the generator is idle. valid is a
// one-cycle strobe with no ready: the selected seq output is new in that cycle and then holds.
interface pattern_gen_if;
    logic        start;
    logic [1:0]  level;
    logic [8:0]  seq1;
    logic [15:0] seq2;
    logic [24:0] seq3;
    logic        busy;
    logic        valid;

    modport master (
        output start, level,
        input  seq1, seq2, seq3, busy, valid
    );

    modport slave (
        input  start, level,
        output seq1, seq2, seq3, busy, valid
    );
endinterface

// File: rtl/pattern_gen.sv
// Random lit-cell pattern generator for 3x3/4x4/5x5 grids using LFSR rejection sampling.
// Build option PATGEN_FREERUN_EN: LFSR free-runs in every state instead of only while picking.
module pattern_gen #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          LIT1 = 3,
    parameter int          LIT2 = 5,
    parameter int          LIT3 = 7
) (
    input  logic          clk,
    input  logic          reset,
    pattern_gen_if.slave  bus,
    output logic [1:0]    state_dbg
);
    // An all-zero Galois LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [4:0]  LIT1_W   = 5'(LIT1);
    localparam logic [4:0]  LIT2_W   = 5'(LIT2);
    localparam logic [4:0]  LIT3_W   = 5'(LIT3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] lfsr, lfsr_step;
    logic [1:0]  level_q, level_n;
    logic [24:0] work, work_n;
    logic [4:0]  count, count_n;
    logic [8:0]  seq1_q;
    logic [15:0] seq2_q;
    logic [24:0] seq3_q;
    logic        valid_q;

    logic [4:0]  n_cells;
    logic [4:0]  lit;
    logic [4:0]  idx;
    logic [24:0] pick_mask;
    logic        accept;

    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    assign idx       = lfsr[4:0];

    always_comb begin
        n_cells = 5'd25;
        lit     = LIT3_W;
        case (level_q)
            2'b01: begin
                n_cells = 5'd9;
                lit     = LIT1_W;
            end
            2'b10: begin
                n_cells = 5'd16;
                lit     = LIT2_W;
            end
            default: begin
                n_cells = 5'd25;
                lit     = LIT3_W;
            end
        endcase
    end

    // idx values of 25..31 shift the one-hot out of range; idx < n_cells rejects them anyway.
    assign pick_mask = 25'd1 << idx;
    assign accept    = (idx < n_cells) && ((work & pick_mask) == 25'd0);

    always_comb begin
        state_n = state;
        level_n = level_q;
        work_n  = work;
        count_n = count;
        case (state)
            IDLE: begin
                if (bus.start && (bus.level != 2'b00)) begin
                    level_n = bus.level;
                    work_n  = 25'd0;
                    count_n = 5'd0;
                    state_n = PICK;
                end
            end
            PICK: begin
                if (accept) begin
                    work_n  = work | pick_mask;
                    count_n = count + 5'd1;
                    if (count_n == lit) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= SEED_EFF;
            level_q <= 2'b00;
            work    <= 25'd0;
            count   <= 5'd0;
            seq1_q  <= 9'd0;
            seq2_q  <= 16'd0;
            seq3_q  <= 25'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            level_q <= level_n;
            work    <= work_n;
            count   <= count_n;
            valid_q <= (state == DONE);
            if (state == DONE) begin
                case (level_q)
                    2'b01:   seq1_q <= work[8:0];
                    2'b10:   seq2_q <= work[15:0];
                    2'b11:   seq3_q <= work;
                    default: ;
                endcase
            end
`ifdef PATGEN_FREERUN_EN
            lfsr <= lfsr_step;
`else
            if (state == PICK) begin
                lfsr <= lfsr_step;
            end
`endif
        end
    end

    assign bus.seq1  = seq1_q;
    assign bus.seq2  = seq2_q;
    assign bus.seq3  = seq3_q;
    assign bus.busy  = (state == PICK);
    assign bus.valid = valid_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: three instances (default seed, zero seed, seed 16'h1234)
// driven through their own interfaces; each task checks its scenario inline.
module tb_pattern_gen;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pattern_gen_if pg();
    pattern_gen_if pz();
    pattern_gen_if pk();
    logic [1:0] dbg_g, dbg_z, dbg_k;

    pattern_gen u_dut (.clk(clk), .reset(reset), .bus(pg), .state_dbg(dbg_g));
    pattern_gen #(.SEED(16'h0000)) u_zero (.clk(clk), .reset(reset), .bus(pz), .state_dbg(dbg_z));
    pattern_gen #(.SEED(16'h1234)) u_k1234 (.clk(clk), .reset(reset), .bus(pk), .state_dbg(dbg_k));

    // Hand-stepped from 16'hACE1: idx 1 (take), 16,24,28,14 (reject), 7 (take), 19,9 (reject),
    // 4 (take) -> cells 1,4,7 after 9 PICK cycles, valid seen 11 edges after the start edge.
    localparam logic [8:0] EXP_FIRST_L1 = 9'h092;
    localparam int         EXP_FIRST_LAT = 11;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    logic [8:0] first_l1;

    always @(posedge clk) begin
        if (pg.valid === 1'b1) vcount <= vcount + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic wait_valid(input int which, input int budget, output int lat, output bit seen);
        logic v;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < budget) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            v = (which == 2) ? pk.valid : pg.valid;
            if (v === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic start_pg(input logic [1:0] lvl);
        pg.start = 1'b1;
        pg.level = lvl;
        @(posedge clk);
        @(negedge clk);
        pg.start = 1'b0;
    endtask

    task automatic test_reset();
        bit busy_seen, valid_seen;
        int base;
        reset = 1'b1;
        pg.start = 1'b1;
        pg.level = 2'b01;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pg.start = 1'b0;
        pg.level = 2'b00;
        base = vcount;
        busy_seen = 1'b0;
        valid_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pg.busy !== 1'b0) busy_seen = 1'b1;
            if (pg.valid !== 1'b0) valid_seen = 1'b1;
        end
        checks++; if (pg.seq1 !== 9'd0) begin errors++; $display("FAIL reset_seq1: got %h required 0", pg.seq1); end
        checks++; if (pg.seq2 !== 16'd0) begin errors++; $display("FAIL reset_seq2: got %h required 0", pg.seq2); end
        checks++; if (pg.seq3 !== 25'd0) begin errors++; $display("FAIL reset_seq3: got %h required 0", pg.seq3); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL reset_busy: busy went high while idle after reset"); end
        checks++; if (valid_seen !== 1'b0 || vcount != base) begin errors++; $display("FAIL reset_valid: valid pulsed %0d times, required 0", vcount - base); end
        checks++; if (dbg_g !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dbg_g); end
    endtask

    task automatic test_level1();
        int lat, base;
        bit seen;
        base = vcount;
        pg.start = 1'b1; pg.level = 2'b01;
        pz.start = 1'b1; pz.level = 2'b01;
        @(posedge clk);
        @(negedge clk);
        pg.start = 1'b0;
        pz.start = 1'b0;
        checks++; if (pg.busy !== 1'b1) begin errors++; $display("FAIL l1_busy_rise: got %b required 1", pg.busy); end
        wait_valid(0, 192, lat, seen);
        checks++; if (!seen) begin errors++; $display("FAIL l1_timeout: no valid within %0d cycles", lat); end
        checks++; if ($countones(pg.seq1) != 3) begin errors++; $display("FAIL l1_popcount: got %0d required 3", $countones(pg.seq1)); end
        checks++; if (pg.seq2 !== 16'd0) begin errors++; $display("FAIL l1_seq2_hold: got %h required 0", pg.seq2); end
        checks++; if (pg.seq3 !== 25'd0) begin errors++; $display("FAIL l1_seq3_hold: got %h required 0", pg.seq3); end
        checks++; if (pz.valid !== 1'b1 || pz.seq1 !== pg.seq1) begin errors++; $display("FAIL l1_seed_zero: got %h valid %b required %h valid 1", pz.seq1, pz.valid, pg.seq1); end
`ifndef PATGEN_FREERUN_EN
        checks++; if (pg.seq1 !== EXP_FIRST_L1) begin errors++; $display("FAIL l1_pattern: got %h required %h", pg.seq1, EXP_FIRST_L1); end
        checks++; if (lat != EXP_FIRST_LAT) begin errors++; $display("FAIL l1_latency: got %0d required %0d", lat, EXP_FIRST_LAT); end
`endif
        first_l1 = pg.seq1;
        @(negedge clk);
        checks++; if (pg.valid !== 1'b0) begin errors++; $display("FAIL l1_pulse_width: valid still %b, required 0", pg.valid); end
        checks++; if (vcount - base != 1) begin errors++; $display("FAIL l1_pulse_count: got %0d required 1", vcount - base); end
    endtask

    task automatic test_level3_then_2();
        int lat;
        bit seen;
        logic [24:0] prev3;
        start_pg(2'b11);
        wait_valid(0, 448, lat, seen);
        checks++; if (!seen) begin errors++; $display("FAIL l3_timeout: no valid within %0d cycles", lat); end
        checks++; if ($countones(pg.seq3) != 7) begin errors++; $display("FAIL l3_popcount: got %0d required 7", $countones(pg.seq3)); end
        checks++; if (pg.seq1 !== first_l1) begin errors++; $display("FAIL l3_seq1_hold: got %h required %h", pg.seq1, first_l1); end
        checks++; if (pg.seq2 !== 16'd0) begin errors++; $display("FAIL l3_seq2_hold: got %h required 0", pg.seq2); end
        prev3 = pg.seq3;
        @(negedge clk);
        start_pg(2'b10);
        wait_valid(0, 320, lat, seen);
        checks++; if (!seen) begin errors++; $display("FAIL l2_timeout: no valid within %0d cycles", lat); end
        checks++; if ($countones(pg.seq2) != 5) begin errors++; $display("FAIL l2_popcount: got %0d required 5", $countones(pg.seq2)); end
        checks++; if (pg.seq3 !== prev3) begin errors++; $display("FAIL l2_seq3_hold: got %h required %h", pg.seq3, prev3); end
        checks++; if (pg.seq1 !== first_l1) begin errors++; $display("FAIL l2_seq1_hold: got %h required %h", pg.seq1, first_l1); end
        @(negedge clk);
    endtask

    task automatic test_mid_build();
        int lat, base;
        bit seen;
        logic [8:0]  prev1;
        logic [24:0] prev3;
        prev1 = pg.seq1;
        prev3 = pg.seq3;
        base = vcount;
        start_pg(2'b10);
        @(negedge clk);
        checks++; if (pg.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", pg.busy); end
        pg.level = 2'b01;
        pg.start = 1'b1;
        @(negedge clk);
        pg.start = 1'b0;
        wait_valid(0, 320, lat, seen);
        checks++; if (!seen) begin errors++; $display("FAIL mid_timeout: no valid within %0d cycles", lat); end
        checks++; if ($countones(pg.seq2) != 5) begin errors++; $display("FAIL mid_popcount: got %0d required 5", $countones(pg.seq2)); end
        checks++; if (pg.seq1 !== prev1) begin errors++; $display("FAIL mid_seq1_hold: got %h required %h", pg.seq1, prev1); end
        checks++; if (pg.seq3 !== prev3) begin errors++; $display("FAIL mid_seq3_hold: got %h required %h", pg.seq3, prev3); end
        repeat (2) @(negedge clk);
        checks++; if (vcount - base != 1 || pg.busy !== 1'b0) begin errors++; $display("FAIL mid_single_build: pulses %0d busy %b, required 1 and 0", vcount - base, pg.busy); end

        // Reset while picking abandons the build.
        start_pg(2'b01);
        @(negedge clk);
        checks++; if (pg.busy !== 1'b1) begin errors++; $display("FAIL rst_pick_busy: got %b required 1", pg.busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (pg.seq1 !== 9'd0 || pg.seq2 !== 16'd0 || pg.seq3 !== 25'd0) begin errors++; $display("FAIL rst_pick_seq: got %h %h %h required all 0", pg.seq1, pg.seq2, pg.seq3); end
        checks++; if (pg.busy !== 1'b0 || pg.valid !== 1'b0) begin errors++; $display("FAIL rst_pick_flags: busy %b valid %b required 0 0", pg.busy, pg.valid); end
        base = vcount;
        repeat (20) @(negedge clk);
        checks++; if (vcount != base) begin errors++; $display("FAIL rst_pick_no_valid: got %0d pulses required 0", vcount - base); end
    endtask

    task automatic test_level00();
        int base;
        bit busy_seen;
        base = vcount;
        busy_seen = 1'b0;
        pg.start = 1'b1;
        pg.level = 2'b00;
        repeat (4) begin
            @(negedge clk);
            if (pg.busy !== 1'b0) busy_seen = 1'b1;
        end
        pg.start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pg.busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (busy_seen) begin errors++; $display("FAIL lvl00_busy: busy went high, required 0"); end
        checks++; if (vcount != base) begin errors++; $display("FAIL lvl00_valid: got %0d pulses required 0", vcount - base); end
    endtask

    task automatic test_determinism();
        int lat;
        bit seen;
        logic [8:0] r1, r2;
        r1 = 9'd0;
        r2 = 9'd0;
        for (int run = 0; run < 2; run++) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            repeat ((run == 0) ? 3 : 17) @(negedge clk);
            pk.start = 1'b1;
            pk.level = 2'b01;
            @(posedge clk);
            @(negedge clk);
            pk.start = 1'b0;
            wait_valid(2, 192, lat, seen);
            checks++; if (!seen) begin errors++; $display("FAIL det_timeout: run %0d no valid within %0d cycles", run, lat); end
            if (run == 0) r1 = pk.seq1;
            else r2 = pk.seq1;
            @(negedge clk);
        end
        checks++; if (r2 !== r1) begin errors++; $display("FAIL det_repeat: got %h required %h", r2, r1); end
        checks++; if ($countones(r1) != 3) begin errors++; $display("FAIL det_popcount: got %0d required 3", $countones(r1)); end
    endtask

    task automatic test_back_to_back();
        int base, pulses, bad_pop, cyc;
        base = vcount;
        pulses = 0;
        bad_pop = 0;
        cyc = 0;
        pg.start = 1'b1;
        pg.level = 2'b01;
        while (pulses < 3 && cyc < 3 * 192) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (pg.valid === 1'b1) begin
                pulses++;
                if ($countones(pg.seq1) != 3) bad_pop++;
                if (pulses == 3) pg.start = 1'b0;
            end
        end
        pg.start = 1'b0;
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d required 3 (cycles %0d)", pulses, cyc); end
        checks++; if (bad_pop != 0) begin errors++; $display("FAIL b2b_popcount: %0d patterns without 3 lit cells, required 0", bad_pop); end
        repeat (2) @(negedge clk);
        checks++; if (pg.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b required 0", pg.busy); end
        checks++; if (vcount - base != 3) begin errors++; $display("FAIL b2b_pulse_count: got %0d required 3", vcount - base); end
    endtask

    initial begin
        reset = 1'b1;
        pg.start = 1'b0; pg.level = 2'b00;
        pz.start = 1'b0; pz.level = 2'b00;
        pk.start = 1'b0; pk.level = 2'b00;
        @(negedge clk);
        test_reset();
        test_level1();
        test_level3_then_2();
        test_mid_build();
        test_level00();
`ifndef PATGEN_FREERUN_EN
        test_determinism();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Upstream feeder of the game brain: produces the random lit-cell patterns `seq1` (3x3), `seq2` (4x4) and `seq3` (5x5) that the brain compares against player input.
- A round request selects the grid level. The block builds a pattern with a fixed number of distinct lit cells by LFSR rejection sampling.
- It then publishes the pattern with a one-cycle valid pulse.

Parameters:
- SEED, 16'hACE1, initial LFSR state; must be nonzero (a 0 value is replaced by 16'hACE1 at elaboration).
- LIT1, 3, lit cells in a level-1 (9-cell) pattern; legal 1..9.
- LIT2, 5, lit cells in a level-2 (16-cell) pattern; legal 1..16.
- LIT3, 7, lit cells in a level-3 (25-cell) pattern; legal 1..25.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request new pattern; sampled only in IDLE.
- level  in  2  01 = 3x3, 10 = 4x4, 11 = 5x5; 00 = no game.
- seq1  out  9  level-1 pattern, bit i = cell i lit.
- seq2  out  16  level-2 pattern.
- seq3  out  25  level-3 pattern.
- busy  out  1  high while a pattern is being built.
- valid  out  1  one-cycle pulse: selected seq output just updated.

Behaviour:
- Reset (synchronous, active-high, dominant over all inputs):
  - seq1 = 0, seq2 = 0, seq3 = 0, busy = 0, valid = 0.
  - lfsr = SEED, FSM = IDLE, work register = 0, count = 0.
  - Reset asserted mid-build abandons the build; no valid pulse is produced.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). Never reaches 0.
- Derived values:
  - N = 9 / 16 / 25 for the latched level.
  - LIT = LIT1 / LIT2 / LIT3 for the latched level.
  - idx = lfsr[4:0].
- FSM states: IDLE, PICK, DONE.
- IDLE:
  - busy = 0.
  - If start = 1 and level != 00: latch level, clear the 25-bit work register and the 5-bit count, go to PICK.
  - start with level = 00 is ignored.
- PICK:
  - busy = 1.
  - Each cycle: if idx < N and work[idx] = 0, set work[idx] and increment count. Otherwise reject; no state change besides the LFSR.
  - When the increment makes count == LIT, go to DONE on the same edge.
  - start and level are ignored while in PICK; the latched level governs.
- DONE (one cycle):
  - Copy work[N-1:0] into the seq output of the latched level. The other two seq outputs hold their previous values.
  - valid = 1 in the cycle after the copy edge, aligned with the new output value.
  - busy = 0, return to IDLE.
- Timing:
  - Minimum latency from start-sampling edge to valid = LIT + 2 cycles, when there are no rejections.
  - There is no upper bound. Bench timeout: 64*LIT cycles.
- Output invariants:
  - seq outputs change only at DONE and are stable otherwise.
  - Bits >= N in the work register are never set.
  - popcount of the published pattern == LIT exactly.
- Back-to-back requests: start held high through DONE triggers a new build on the first IDLE cycle after DONE. Each request produces exactly one valid pulse.

Optional Feature:
- Macro: PATGEN_FREERUN_EN.
- Defined: the LFSR advances every cycle in every state (except reset). Pattern content then depends on the cycle at which the player presses start; this is the production randomness.
- Undefined: the LFSR advances only in PICK cycles. The pattern sequence is then a pure function of SEED and request order, independent of idle time; used for reproducible simulation.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles, then 20 idle cycles -> seq1/seq2/seq3 = 0, busy = 0, valid never asserts.
- Level 1 build: start = 1, level = 01 for one cycle -> busy rises next cycle; valid pulses exactly once within 192 cycles. At valid: popcount(seq1) = 3, seq2 = seq3 = 0.
- Level 3 build: start with level = 11 -> at valid, popcount(seq3) = 7 and seq1/seq2 unchanged. Repeat with level = 10 -> popcount(seq2) = 5, seq3 holds its previous pattern.
- Mid-build disturbance: start a level-2 build, toggle level to 01 and pulse start during PICK -> ignored; result lands in seq2 only with popcount 5. A separate run asserts reset during PICK -> all outputs 0 next cycle, no valid pulse.
- Determinism (PATGEN_FREERUN_EN undefined): two runs with SEED = 16'h1234 and different idle gaps before start -> identical seq1 values. Run with SEED = 0 -> same result as SEED = 16'hACE1.
- Level 00 and back-to-back: start with level = 00 -> busy stays 0, no valid. Start held high with level = 01 for 3 builds -> 3 valid pulses, each seq1 with popcount 3.
